mem_port_arbiter: RTL and testbench

- Round-robin arbiter that shares one word-wide memory port between NREQ requesters.
- Default requesters: CPU port plus MJPEG_MMAP master ports 0 and 1.
- Replaces the current scheme, where each port has its own always block writing the same memory array.
- Serialises requests onto a single valid/ready downstream port and routes the response back to the granted requester. Also adds a watchdog on the downstream response.

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between NREQ requesters,
// with a response watchdog. Define MEM_ARB_STATS_EN to add per-requester statistics counters.
module mem_port_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*4-1:0]        req_wstrb,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     mem_valid,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [3:0]               mem_wstrb,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [NREQ-1:0]          grant,
  output logic                     err_timeout
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0]       stat_grants,
  output logic [NREQ*32-1:0]       stat_wait
`endif
);

  localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [DATA_W-1:0] ABORT_DATA = DATA_W'(32'hDEAD_BEEF);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic [CNT_W-1:0]  wd_cnt;

  logic [ADDR_W-1:0] addr_arr  [NREQ];
  logic [DATA_W-1:0] wdata_arr [NREQ];
  logic [3:0]        wstrb_arr [NREQ];

  logic [IDX_W-1:0]  pick;
  logic              pick_ok;
  int unsigned       slot;
  logic [NREQ-1:0]   owner_oh;
  logic [IDX_W-1:0]  next_ptr;
  logic              busy_done;
  logic              busy_abort;

  // Per-requester views of the flat request buses
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*ADDR_W +: ADDR_W];
    assign wdata_arr[g] = req_wdata[g*DATA_W +: DATA_W];
    assign wstrb_arr[g] = req_wstrb[g*4 +: 4];
  end

  // First valid requester at or after the pointer, wrapping around
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    slot    = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      slot = 32'(ptr) + k;
      if (slot >= NREQ) slot = slot - NREQ;
      if (!pick_ok && req_valid[IDX_W'(slot)]) begin
        pick    = IDX_W'(slot);
        pick_ok = 1'b1;
      end
    end
  end

  assign owner_oh   = NREQ'(1) << owner;
  assign next_ptr   = IDX_W'((32'(owner) + 32'd1) % NREQ);
  assign busy_done  = (state == BUSY) && mem_ready;
  assign busy_abort = (state == BUSY) && !mem_ready && (TIMEOUT != 0) &&
                      (wd_cnt == CNT_W'(TO_LAST));

  // Arbitration FSM; every output is a register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      wd_cnt      <= '0;
      grant       <= '0;
      req_ready   <= '0;
      req_rdata   <= '0;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wstrb   <= '0;
      mem_wdata   <= '0;
      err_timeout <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ok) begin
            owner     <= pick;
            grant     <= NREQ'(1) << pick;
            mem_valid <= 1'b1;
            mem_addr  <= addr_arr[pick];
            mem_wstrb <= wstrb_arr[pick];
            mem_wdata <= wdata_arr[pick];
            wd_cnt    <= '0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (busy_done) begin
            mem_valid <= 1'b0;
            req_ready <= owner_oh;
            req_rdata <= (mem_wstrb != 4'h0) ? '0 : mem_rdata;
            ptr       <= next_ptr;
            state     <= RESP;
          end else if (busy_abort) begin
            // Abandon the downstream access and complete with a marker word
            err_timeout <= 1'b1;
            mem_valid   <= 1'b0;
            req_ready   <= owner_oh;
            req_rdata   <= ABORT_DATA;
            ptr         <= next_ptr;
            state       <= RESP;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        RESP: begin
          req_ready <= '0;
          req_rdata <= '0;
          grant     <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  // Completed transactions and cycles spent waiting, per requester; wrap at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants <= '0;
      stat_wait   <= '0;
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if ((busy_done || busy_abort) && (owner == IDX_W'(i)))
          stat_grants[i*32 +: 32] <= stat_grants[i*32 +: 32] + 32'd1;
        if (req_valid[i] && !grant[i])
          stat_wait[i*32 +: 32] <= stat_wait[i*32 +: 32] + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vectors, table-driven arbitration
// order, watchdog/reset corner cases and randomized traffic against a transaction model.
module tb_mem_port_arbiter;

  localparam int NREQ = 3;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int TB_TIMEOUT = 8;

  logic clk;
  logic rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*4-1:0]      req_wstrb;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        req_ready;
  logic [DATA_W-1:0]      req_rdata;
  logic                   mem_valid;
  logic [ADDR_W-1:0]      mem_addr;
  logic [3:0]             mem_wstrb;
  logic [DATA_W-1:0]      mem_wdata;
  logic                   mem_ready;
  logic [DATA_W-1:0]      mem_rdata;
  logic [NREQ-1:0]        grant;
  logic                   err_timeout;
`ifdef MEM_ARB_STATS_EN
  logic [NREQ*32-1:0]     stat_grants;
  logic [NREQ*32-1:0]     stat_wait;
`endif

  logic [ADDR_W-1:0] r_addr  [NREQ];
  logic [3:0]        r_wstrb [NREQ];
  logic [DATA_W-1:0] r_wdata [NREQ];

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*ADDR_W +: ADDR_W]  = r_addr[i];
      req_wstrb[i*4 +: 4]           = r_wstrb[i];
      req_wdata[i*DATA_W +: DATA_W] = r_wdata[i];
    end
  end

  mem_port_arbiter #(
    .NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wstrb(req_wstrb), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .req_rdata(req_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .grant(grant), .err_timeout(err_timeout)
`ifdef MEM_ARB_STATS_EN
    , .stat_grants(stat_grants), .stat_wait(stat_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: arbitration phase, owner, pointer, sticky error, shadow memory
  int m_phase;
  int m_owner;
  int m_ptr;
  int m_wcnt;
  bit m_err;
  logic [ADDR_W-1:0] m_addr;
  logic [3:0]        m_wstrb;
  logic [DATA_W-1:0] m_wdata;
  logic [31:0] sh_mem  [bit [31:0]];
  logic [31:0] dev_mem [bit [31:0]];

  // Memory responder and requester behaviour knobs
  int d_cnt;
  int d_lat;
  int lat_cfg;
  bit hang;
  bit rand_mode;
  bit rearm;

  typedef struct packed {
    logic [2:0]      mask;
    logic [3:0]      lat;
    logic [1:0]      n;
    logic [2:0][1:0] ord;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  function automatic logic [31:0] init_word(input bit [31:0] w);
    return 32'hA5C3_0000 ^ (w * 32'h0000_9E37);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] sh_rd(input bit [31:0] w);
    return sh_mem.exists(w) ? sh_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] dev_rd(input bit [31:0] w);
    return dev_mem.exists(w) ? dev_mem[w] : init_word(w);
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (p + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic issue(input int i, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    r_addr[i]    = a;
    r_wstrb[i]   = s;
    r_wdata[i]   = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic new_req(input int i);
    logic [3:0] s;
    s = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    issue(i, 32'($urandom_range(0, 15)) << 2, s, $urandom);
  endtask

  task automatic preload(input bit [31:0] w, input logic [31:0] val);
    dev_mem[w] = val;
    sh_mem[w]  = val;
  endtask

  // One clock: advance the model, compare, then let memory and requesters react
  task automatic step();
    logic [NREQ-1:0] v;
    logic            mr;
    logic [NREQ-1:0] e_ready;
    logic [NREQ-1:0] e_grant;
    logic            e_valid;
    logic [31:0]     e_rdata;
    bit              timed_out;
    bit [31:0]       w;
    v = req_valid;
    mr = mem_ready;
    @(posedge clk);
    #1;
    e_ready = '0;
    e_rdata = '0;
    case (m_phase)
      0: if (v != 0) begin
        m_owner = pick(v, m_ptr);
        m_addr  = r_addr[m_owner];
        m_wstrb = r_wstrb[m_owner];
        m_wdata = r_wdata[m_owner];
        m_wcnt  = 0;
        m_phase = 1;
      end
      1: begin
        timed_out = !mr && (m_wcnt + 1 == TB_TIMEOUT);
        if (mr || timed_out) begin
          e_ready = NREQ'(1) << m_owner;
          if (timed_out) begin
            e_rdata = 32'hDEAD_BEEF;
            m_err   = 1'b1;
          end else if (m_wstrb != 0) begin
            sh_mem[m_addr >> 2] = merge(sh_rd(m_addr >> 2), m_wdata, m_wstrb);
          end else begin
            e_rdata = sh_rd(m_addr >> 2);
          end
          m_ptr   = (m_owner + 1) % NREQ;
          m_phase = 2;
        end else begin
          m_wcnt++;
        end
      end
      default: m_phase = 0;
    endcase
    e_grant = (m_phase != 0) ? NREQ'(1) << m_owner : '0;
    e_valid = (m_phase == 1);
    check("ctrl{grant,ready,mem_valid,err}", {grant, req_ready, mem_valid, err_timeout},
          {e_grant, e_ready, e_valid, m_err});
    if (e_valid) check("mem_bus", {mem_addr, mem_wstrb, mem_wdata}, {m_addr, m_wstrb, m_wdata});
    if (e_ready != 0) check("req_rdata", req_rdata, e_rdata);

    mem_ready = 1'b0;
    mem_rdata = $urandom;
    if (mem_valid && !hang) begin
      if (d_cnt == 0) d_lat = rand_mode ? $urandom_range(1, 5) : lat_cfg;
      d_cnt++;
      if (d_cnt >= d_lat) begin
        mem_ready = 1'b1;
        w = mem_addr >> 2;
        if (mem_wstrb != 0) dev_mem[w] = merge(dev_rd(w), mem_wdata, mem_wstrb);
        else mem_rdata = dev_rd(w);
      end
    end else if (!mem_valid) begin
      d_cnt = 0;
    end

    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        req_valid[i] = 1'b0;
        if (rearm || (rand_mode && $urandom_range(0, 1) == 1)) new_req(i);
      end else if (rand_mode && !req_valid[i] && $urandom_range(0, 3) == 0) begin
        new_req(i);
      end
    end
  endtask

  task automatic wait_ready(input string name, output int idx);
    idx = -1;
    for (int c = 0; c < 60; c++) begin
      step();
      if (req_ready != 0) begin
        for (int k = 0; k < NREQ; k++) if (req_ready[k]) idx = k;
        return;
      end
    end
    bound_fail(name);
  endtask

  task automatic settle();
    for (int c = 0; c < 200; c++) begin
      if (m_phase == 0 && req_valid == 0) return;
      step();
    end
    bound_fail("settle");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_async_outputs",
          {req_ready, req_rdata, mem_valid, mem_addr, mem_wstrb, mem_wdata, grant, err_timeout},
          '0);
    req_valid = '0;
    mem_ready = 1'b0;
    d_cnt = 0;
    hang = 1'b0;
    rearm = 1'b0;
    m_phase = 0;
    m_ptr = 0;
    m_err = 1'b0;
    sh_mem.delete();
    dev_mem.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t tbl [5];

  initial begin
    int idx;
    int hi;
    rst = 1'b0;
    req_valid = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    lat_cfg = 1;
    rand_mode = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = '0;
      r_wstrb[i] = '0;
      r_wdata[i] = '0;
    end
    // Arbitration order per vector, pointer starting at 1 after the single read
    tbl[0] = '{mask: 3'b111, lat: 4'd1, n: 2'd3, ord: {2'd0, 2'd2, 2'd1}};
    tbl[1] = '{mask: 3'b101, lat: 4'd3, n: 2'd2, ord: {2'd0, 2'd0, 2'd2}};
    tbl[2] = '{mask: 3'b011, lat: 4'd2, n: 2'd2, ord: {2'd0, 2'd0, 2'd1}};
    tbl[3] = '{mask: 3'b100, lat: 4'd4, n: 2'd1, ord: {2'd0, 2'd0, 2'd2}};
    tbl[4] = '{mask: 3'b110, lat: 4'd1, n: 2'd2, ord: {2'd0, 2'd2, 2'd1}};
    #3;
    do_reset();

    // Single read with a two-cycle memory
    preload(32'h0001_0000 >> 2, 32'h1234_5678);
    lat_cfg = 2;
    issue(0, 32'h0001_0000, 4'h0, 32'h0);
    step();
    check("sr_mem_valid", mem_valid, 1'b1);
    check("sr_grant", grant, 3'b001);
    step();
    check("sr_not_yet", req_ready, 3'b000);
    step();
    check("sr_ready", req_ready, 3'b001);
    check("sr_rdata", req_rdata, 32'h1234_5678);
    step();
    check("sr_grant_idle", grant, 3'b000);
    check("sr_ready_drop", req_ready, 3'b000);
    settle();

    // Table-driven arbitration order
    for (int v = 0; v < 5; v++) begin
      lat_cfg = int'(tbl[v].lat);
      for (int i = 0; i < NREQ; i++)
        if (tbl[v].mask[i]) issue(i, 32'h100 + 32'(v * 16 + i * 4), 4'h0, 32'h0);
      for (int k = 0; k < int'(tbl[v].n); k++) begin
        wait_ready("tbl_wait", idx);
        check("tbl_order", 32'(idx), 32'(tbl[v].ord[k]));
        if (idx >= 0)
          check("tbl_rdata", req_rdata, init_word((32'h100 + 32'(v * 16 + idx * 4)) >> 2));
      end
    end
    settle();

    // Write from requester 2, then read back by requester 1
    lat_cfg = 1;
    issue(2, 32'h0002_0000, 4'hF, 32'hCAFE_F00D);
    step();
    check("wr_grant", grant, 3'b100);
    check("wr_wstrb", mem_wstrb, 4'hF);
    wait_ready("wr_wait", idx);
    check("wr_rdata_zero", req_rdata, 32'h0);
    settle();
    issue(1, 32'h0002_0000, 4'h0, 32'h0);
    step();
    check("rd_grant", grant, 3'b010);
    wait_ready("rd_wait", idx);
    check("rd_back", req_rdata, 32'hCAFE_F00D);
    settle();

    // Round robin with all requesters continuously valid, from a fresh reset
    do_reset();
    lat_cfg = 1;
    rearm = 1'b1;
    for (int i = 0; i < NREQ; i++) issue(i, 32'h40 + 32'(i * 4), 4'h0, 32'h0);
    for (int k = 0; k < 6; k++) begin
      wait_ready("rr_wait", idx);
      check("rr_order", 32'(idx), 32'(k % NREQ));
    end
`ifdef MEM_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) check("stat_grants", stat_grants[i*32 +: 32], 32'd2);
    check("stat_wait1_nz", stat_wait[32 +: 32] != 0, 1'b1);
    check("stat_wait2_nz", stat_wait[64 +: 32] != 0, 1'b1);
`endif
    rearm = 1'b0;
    settle();

    // Watchdog: memory never answers
    hang = 1'b1;
    issue(0, 32'h0000_0040, 4'h0, 32'h0);
    hi = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (mem_valid) hi++;
      if (req_ready != 0) break;
    end
    check("wd_valid_cycles", 32'(hi), 32'd8);
    check("wd_err", err_timeout, 1'b1);
    check("wd_ready", req_ready, 3'b001);
    check("wd_rdata", req_rdata, 32'hDEAD_BEEF);
    mem_ready = 1'b1;
    step();
    check("wd_late_ready_resp", {err_timeout, req_ready}, {1'b1, 3'b000});
    mem_ready = 1'b1;
    step();
    check("wd_late_ready_idle", {mem_valid, req_ready, grant}, '0);
    hang = 1'b0;
    issue(1, 32'h0000_0044, 4'h0, 32'h0);
    wait_ready("wd_after_wait", idx);
    check("wd_after_idx", 32'(idx), 32'd1);
    check("wd_sticky", err_timeout, 1'b1);
    settle();

    // Reset in the middle of a downstream transaction
    hang = 1'b1;
    issue(1, 32'h0000_0080, 4'h0, 32'h0);
    step();
    check("mid_busy", mem_valid, 1'b1);
    #2;
    do_reset();
    for (int i = 0; i < NREQ; i++) issue(i, 32'h0000_00C0 + 32'(i * 4), 4'h0, 32'h0);
    step();
    check("rst_first_grant", grant, 3'b001);
    settle();

    // Randomized traffic against the model
    rand_mode = 1'b1;
    for (int c = 0; c < 800; c++) step();
    rand_mode = 1'b0;
    settle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
